send_arb: RTL and testbench
===========================

SEND_ARB -- requirements
Module: send_arb

Interface
REQ-001 SHALL have parameter GAP_CYC, default 16: idle cycles inserted after each frame (range 1..255).
REQ-002 SHALL have parameter TIMEOUT, default 50000: cycles allowed in SEND before abort (16-bit counter).
REQ-003 SHALL have port clk  in  1  system clock; all logic is in this single clock domain.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  in  4  per-requester frame request; level, held by the requester until its ack.
REQ-006 SHALL have port req_len  in  52  lane i = bits [13i+12:13i], frame length of requester i.
REQ-007 SHALL have port hold  in  1  read path busy; blocks new grants only.
REQ-008 SHALL have port fs_send  out  1  start-send request to com.
REQ-009 SHALL have port fd_send  in  1  send-done from com.
REQ-010 SHALL have port data_idx  out  4  binary index (0..3) of the granted requester.
REQ-011 SHALL have port data_len  out  13  latched length of the granted frame.
REQ-012 SHALL have port ack  out  4  one-hot, one-cycle completion pulse.
REQ-013 SHALL have port busy  out  1  high in every state except IDLE.
REQ-014 SHALL have port err_timeout  out  1  sticky timeout flag.
REQ-015 SHALL have port err_clr  in  1  clears err_timeout.

Function
REQ-016 SHALL implement states IDLE, SEND, GAP.
REQ-017 In IDLE with hold=0 and req!=0, SHALL grant on that clock edge; fs_send=1, data_idx and data_len are valid in the next cycle (1-cycle latency), and the state becomes SEND.
REQ-018 Arbitration SHALL be round-robin: search from (ptr+1) mod 4 upward with wrap; ptr is loaded with the granted index on every grant.
REQ-019 data_idx and data_len SHALL stay constant from grant until the next grant.
REQ-020 A granted requester with req_len lane = 0 SHALL not raise fs_send; its ack SHALL pulse in the cycle after grant, and the state SHALL go to GAP.
REQ-021 In SEND, fs_send SHALL stay 1 until fd_send is sampled 1. In the next cycle fs_send=0, ack[data_idx]=1 for one cycle, and the state goes to GAP.
REQ-022 In SEND, the timeout counter SHALL start at 0 on entry and increment each cycle. When it reaches TIMEOUT-1 with fd_send=0: fs_send=0, err_timeout=1, no ack, state goes to GAP.
REQ-023 If fd_send=1 occurs in the same cycle as the timeout limit, it SHALL be treated as success (ack, no error).
REQ-024 In GAP, the state SHALL return to IDLE only after GAP_CYC cycles have elapsed and fd_send is sampled 0; the gap counter saturates while waiting for fd_send low.
REQ-025 hold, or any change on req or req_len, during SEND or GAP SHALL not affect the frame in progress.
REQ-026 A requester still asserting req after its ack SHALL be arbitrated normally at the next IDLE, so round-robin prevents starvation.
REQ-027 fd_send=1 while in IDLE SHALL be ignored.
REQ-028 err_clr=1 SHALL clear err_timeout next cycle. If err_clr=1 coincides with a new timeout, set SHALL win.
REQ-029 ack SHALL never have more than one bit set, and SHALL be 0 in all cycles except the completion pulse.

Reset
REQ-030 While rst=1, asynchronously: state=IDLE, fs_send=0, data_idx=0, data_len=0, ack=0, busy=0, err_timeout=0, ptr=3 (requester 0 is first priority), all counters 0.
REQ-031 rst asserted mid-SEND SHALL drop fs_send immediately, with no ack and no error flag.
REQ-032 The first grant after rst deasserts SHALL be possible on the first clock edge.

Verification
REQ-033 After reset, req=4'b1111 with all lengths 100 and fd_send returned 5 cycles after fs_send -> grants in order 0,1,2,3,0; each ack bit pulses exactly once per frame; frames are separated by 16 or more idle cycles.
REQ-034 req=4'b0100, len=1500, hold=1 for 20 cycles then 0 -> no fs_send while hold=1; fs_send rises 1 cycle after hold falls; data_idx=2, data_len=1500.
REQ-035 Bench with TIMEOUT=10, fd_send never asserted -> fs_send falls after 10 SEND cycles; err_timeout=1 and stays set through GAP; err_clr pulse clears it; ack never pulses.
REQ-036 req=4'b0010, lane1 len=0 -> fs_send stays 0; ack=4'b0010 pulses 1 cycle after grant; next grant only after the gap.
REQ-037 rst pulsed 3 cycles into SEND -> fs_send=0 asynchronously, all outputs at reset values; with req still 4'b0001, the next grant is to index 0.
REQ-038 fd_send held high for 40 cycles after the frame -> state stays in GAP until fd_send falls; no regrant occurs while fd_send=1.

Source files
------------

// File: rtl/send_arb.sv
// send_arb: round-robin arbiter for four frame requesters sharing one send path.
// A grant latches the requester index and frame length. The send handshake
// (fs_send/fd_send) then runs, guarded by a timeout. A fixed idle gap follows
// before the next grant is allowed.
module send_arb #(
  parameter int GAP_CYC = 16,
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [51:0] req_len,
  input  logic        hold,
  output logic        fs_send,
  input  logic        fd_send,
  output logic [3:0]  data_idx,
  output logic [12:0] data_len,
  output logic [3:0]  ack,
  output logic        busy,
  output logic        err_timeout,
  input  logic        err_clr
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  // Terminal counts: the SEND counter starts at 0 on entry, and so does the GAP counter.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYC - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  idx_q, idx_d;
  logic [12:0] len_q, len_d;
  logic        fs_q, fs_d;
  logic [3:0]  ack_q, ack_d;
  logic        err_q, err_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  gap_q, gap_d;

  logic        grant_valid;
  logic [1:0]  grant_idx;
  logic [12:0] grant_len;

  // Round-robin search starting one past the last granted index, wrapping at 4.
  always_comb begin
    logic [1:0] cand;
    grant_valid = 1'b0;
    grant_idx   = 2'd0;
    cand        = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + k[1:0];
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Select the length lane of the candidate requester.
  always_comb begin
    case (grant_idx)
      2'd0:    grant_len = req_len[12:0];
      2'd1:    grant_len = req_len[25:13];
      2'd2:    grant_len = req_len[38:26];
      default: grant_len = req_len[51:39];
    endcase
  end

  // Next-state logic for the IDLE/SEND/GAP controller and its counters.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    fs_d    = fs_q;
    ack_d   = 4'b0000;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    // A clear request loses to a timeout raised in the same cycle (set below).
    err_d   = err_clr ? 1'b0 : err_q;

    case (state_q)
      ST_IDLE: begin
        tmo_d = 16'd0;
        gap_d = 8'd0;
        fs_d  = 1'b0;
        if (!hold && grant_valid) begin
          ptr_d = grant_idx;
          idx_d = grant_idx;
          len_d = grant_len;
          if (grant_len == 13'd0) begin
            // An empty frame completes at once and never starts a send.
            ack_d   = 4'b0001 << grant_idx;
            state_d = ST_GAP;
          end else begin
            fs_d    = 1'b1;
            state_d = ST_SEND;
          end
        end
      end

      ST_SEND: begin
        if (fd_send) begin
          // Done wins even when it lands on the final timeout cycle.
          fs_d    = 1'b0;
          ack_d   = 4'b0001 << idx_q;
          gap_d   = 8'd0;
          state_d = ST_GAP;
        end else if (tmo_q == TMO_LAST) begin
          fs_d    = 1'b0;
          err_d   = 1'b1;
          gap_d   = 8'd0;
          state_d = ST_GAP;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          // Saturate here until com drops its done line.
          if (!fd_send) begin
            gap_d   = 8'd0;
            state_d = ST_IDLE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end

      default: begin
        fs_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 as first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= 2'd3;
      idx_q   <= 2'd0;
      len_q   <= 13'd0;
      fs_q    <= 1'b0;
      ack_q   <= 4'b0000;
      err_q   <= 1'b0;
      tmo_q   <= 16'd0;
      gap_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      fs_q    <= fs_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
    end
  end

  assign fs_send     = fs_q;
  assign data_idx    = {2'b00, idx_q};
  assign data_len    = len_q;
  assign ack         = ack_q;
  assign busy        = (state_q != ST_IDLE);
  assign err_timeout = err_q;

endmodule

// File: tb/tb_send_arb.sv
// tb_send_arb: directed test of send_arb. The DUT runs with TIMEOUT=10 so the
// abort path is reachable in a short run.
module tb_send_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [51:0] req_len;
  logic        hold;
  logic        fs_send;
  logic        fd_send;
  logic [3:0]  data_idx;
  logic [12:0] data_len;
  logic [3:0]  ack;
  logic        busy;
  logic        err_timeout;
  logic        err_clr;

  int assertCount = 0;
  int failCount   = 0;
  int ackSeen[4]  = '{0, 0, 0, 0};
  int ackMulti    = 0;

  send_arb #(.GAP_CYC(16), .TIMEOUT(10)) dut (
    .clk(clk), .rst(rst), .req(req), .req_len(req_len), .hold(hold),
    .fs_send(fs_send), .fd_send(fd_send), .data_idx(data_idx),
    .data_len(data_len), .ack(ack), .busy(busy),
    .err_timeout(err_timeout), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // Tally ack pulses per requester and flag any multi-hot ack.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) if (ack[i]) ackSeen[i]++;
      if ($countones(ack) > 1) ackMulti++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    if (obs !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [12:0] l0, input logic [12:0] l1,
                               input logic [12:0] l2, input logic [12:0] l3);
    req     = r;
    req_len = {l3, l2, l1, l0};
  endtask

  task automatic waitFs(input int maxCyc, output int n);
    n = 0;
    while (fs_send !== 1'b1 && n < maxCyc) begin
      step(1);
      n++;
    end
    if (fs_send !== 1'b1) checkOutput("fs_wait_expired", 0, 1);
  endtask

  task automatic waitIdle(input int maxCyc);
    int n = 0;
    while (busy !== 1'b0 && n < maxCyc) begin
      step(1);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle_wait_expired", 1, 0);
  endtask

  initial begin
    int n;
    int hi;
    int bad;
    int ack0;
    rst = 1'b1; hold = 1'b0; fd_send = 1'b0; err_clr = 1'b0;
    applyStimulus(4'b0000, 13'd0, 13'd0, 13'd0, 13'd0);
    step(3);
    checkOutput("rst_fs_send", fs_send, 0);
    checkOutput("rst_data_idx", data_idx, 0);
    checkOutput("rst_data_len", data_len, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err_timeout, 0);

    // All four requesting, length 100, done returned 5 cycles after start.
    applyStimulus(4'b1111, 13'd100, 13'd100, 13'd100, 13'd100);
    rst = 1'b0;
    for (int f = 0; f < 5; f++) begin
      waitFs(60, n);
      if (f == 0) checkOutput("first_grant_latency", n, 1);
      else        checkOutput("rr_gap_ge16", (n >= 16), 1);
      checkOutput("rr_idx", data_idx, f % 4);
      checkOutput("rr_len", data_len, 100);
      step(5);
      checkOutput("rr_fs_held", fs_send, 1);
      fd_send = 1'b1;
      step(1);
      fd_send = 1'b0;
      checkOutput("rr_fs_drop", fs_send, 0);
      checkOutput("rr_ack", ack, 4'b0001 << (f % 4));
      if (f == 4) req = 4'b0000;
      step(1);
      checkOutput("rr_ack_one_cycle", ack, 0);
    end
    checkOutput("ack_cnt0", ackSeen[0], 2);
    checkOutput("ack_cnt1", ackSeen[1], 1);
    checkOutput("ack_cnt2", ackSeen[2], 1);
    checkOutput("ack_cnt3", ackSeen[3], 1);
    waitIdle(40);

    // Hold blocks the grant; it fires one cycle after hold drops.
    applyStimulus(4'b0100, 13'd0, 13'd0, 13'd1500, 13'd0);
    hold = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (fs_send !== 1'b0) bad++;
    end
    checkOutput("hold_no_fs", bad, 0);
    hold = 1'b0;
    step(1);
    checkOutput("hold_fs_rise", fs_send, 1);
    checkOutput("hold_idx", data_idx, 2);
    checkOutput("hold_len", data_len, 1500);
    req = 4'b0000;
    fd_send = 1'b1;
    step(1);
    fd_send = 1'b0;
    checkOutput("hold_ack", ack, 4'b0100);
    waitIdle(40);

    // Zero-length frame on requester 1: ack without a send, then a full gap.
    applyStimulus(4'b0010, 13'd100, 13'd0, 13'd0, 13'd0);
    step(1);
    checkOutput("zl_fs", fs_send, 0);
    checkOutput("zl_ack", ack, 4'b0010);
    checkOutput("zl_busy", busy, 1);
    checkOutput("zl_idx", data_idx, 1);
    req = 4'b0001;
    bad = 0;
    for (int i = 0; i < 15; i++) begin
      step(1);
      if (fs_send !== 1'b0) bad++;
    end
    checkOutput("zl_gap_no_fs", bad, 0);
    waitFs(10, n);
    checkOutput("zl_next_idx", data_idx, 0);
    req = 4'b0000;
    fd_send = 1'b1;
    step(1);
    fd_send = 1'b0;
    checkOutput("zl_next_ack", ack, 4'b0001);
    waitIdle(40);

    // Timeout: done never arrives; fs_send lasts exactly 10 cycles.
    ack0 = ackSeen[0];
    applyStimulus(4'b0001, 13'd64, 13'd0, 13'd0, 13'd0);
    waitFs(10, n);
    req = 4'b0000;
    hi = 0;
    while (fs_send === 1'b1 && hi < 50) begin
      hi++;
      step(1);
    end
    checkOutput("tmo_fs_cycles", hi, 10);
    checkOutput("tmo_err_set", err_timeout, 1);
    checkOutput("tmo_busy_gap", busy, 1);
    step(5);
    checkOutput("tmo_err_sticky", err_timeout, 1);
    err_clr = 1'b1;
    step(1);
    err_clr = 1'b0;
    checkOutput("tmo_err_clr", err_timeout, 0);
    checkOutput("tmo_no_ack", ackSeen[0], ack0);
    waitIdle(40);

    // Done held high for 40 cycles: the controller must stay in GAP.
    applyStimulus(4'b0001, 13'd100, 13'd0, 13'd0, 13'd0);
    waitFs(10, n);
    fd_send = 1'b1;
    step(1);
    checkOutput("fdh_ack", ack, 4'b0001);
    bad = 0;
    for (int i = 0; i < 39; i++) begin
      step(1);
      if (fs_send !== 1'b0 || busy !== 1'b1) bad++;
    end
    checkOutput("fdh_stay_gap", bad, 0);
    fd_send = 1'b0;
    waitFs(10, n);
    checkOutput("fdh_regrant_latency", n, 2);
    checkOutput("fdh_idx", data_idx, 0);

    // Reset three cycles into SEND drops everything immediately.
    step(3);
    #2 rst = 1'b1;
    #1;
    checkOutput("mid_rst_fs", fs_send, 0);
    checkOutput("mid_rst_len", data_len, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_ack", ack, 0);
    checkOutput("mid_rst_err", err_timeout, 0);
    step(1);
    rst = 1'b0;
    step(1);
    checkOutput("post_rst_fs", fs_send, 1);
    checkOutput("post_rst_idx", data_idx, 0);
    req = 4'b0000;
    fd_send = 1'b1;
    step(1);
    fd_send = 1'b0;
    checkOutput("post_rst_ack", ack, 4'b0001);
    step(2);
    checkOutput("ack_never_multi", ackMulti, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
